// File: rtl/control_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers with load-use stall and redirect flush.
// Optional stall/flush performance counters are enabled by defining CTRL_PIPE_COUNTERS_EN.
module control_pipeline #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic                      id_write,
  input  logic                      id_store,
  input  logic                      id_load,
  input  logic                      id_branch,
  input  logic [1:0]                id_alu_operand_a_selector,
  input  logic                      id_alu_operand_b_selector,
  input  logic [1:0]                id_next_pc_selector,
  input  logic [2:0]                id_alu_operations_selector,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      ex_redirect,
  output logic                      ex_valid,
  output logic                      ex_write,
  output logic                      ex_store,
  output logic                      ex_load,
  output logic                      ex_branch,
  output logic [1:0]                ex_alu_operand_a_selector,
  output logic                      ex_alu_operand_b_selector,
  output logic [1:0]                ex_next_pc_selector,
  output logic [2:0]                ex_alu_operations_selector,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      mem_valid,
  output logic                      mem_write,
  output logic                      mem_store,
  output logic                      mem_load,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output logic                      wb_valid,
  output logic                      wb_write,
  output logic                      wb_load,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
`ifdef CTRL_PIPE_COUNTERS_EN
  output logic [COUNT_WIDTH-1:0]    stall_count,
  output logic [COUNT_WIDTH-1:0]    flush_count,
`endif
  output logic                      stall,
  output logic                      flush
);

  logic                      ex_valid_r, ex_write_r, ex_store_r, ex_load_r, ex_branch_r;
  logic [1:0]                ex_a_sel_r;
  logic                      ex_b_sel_r;
  logic [1:0]                ex_npc_sel_r;
  logic [2:0]                ex_alu_op_r;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_r;
  logic                      mem_valid_r, mem_write_r, mem_store_r, mem_load_r;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_r;
  logic                      wb_valid_r, wb_write_r, wb_load_r;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_r;
  logic                      hazard;

  always_comb begin
    hazard = ex_valid_r & ex_load_r & id_valid & (ex_rd_r != '0) &
             ((ex_rd_r == id_rs1) | (ex_rd_r == id_rs2));
    flush  = ~rst & ex_redirect;
    stall  = ~rst & hazard & ~ex_redirect;
  end

  // Redirect squashes the decode slot, a stall inserts a bubble, and an
  // invalid decode slot is captured as a fully zeroed bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_r   <= 1'b0;
      ex_write_r   <= 1'b0;
      ex_store_r   <= 1'b0;
      ex_load_r    <= 1'b0;
      ex_branch_r  <= 1'b0;
      ex_a_sel_r   <= '0;
      ex_b_sel_r   <= 1'b0;
      ex_npc_sel_r <= '0;
      ex_alu_op_r  <= '0;
      ex_rd_r      <= '0;
    end else if (ex_redirect || stall || !id_valid) begin
      ex_valid_r   <= 1'b0;
      ex_write_r   <= 1'b0;
      ex_store_r   <= 1'b0;
      ex_load_r    <= 1'b0;
      ex_branch_r  <= 1'b0;
      ex_a_sel_r   <= '0;
      ex_b_sel_r   <= 1'b0;
      ex_npc_sel_r <= '0;
      ex_alu_op_r  <= '0;
      ex_rd_r      <= '0;
    end else begin
      ex_valid_r   <= 1'b1;
      ex_write_r   <= id_write;
      ex_store_r   <= id_store;
      ex_load_r    <= id_load;
      ex_branch_r  <= id_branch;
      ex_a_sel_r   <= id_alu_operand_a_selector;
      ex_b_sel_r   <= id_alu_operand_b_selector;
      ex_npc_sel_r <= id_next_pc_selector;
      ex_alu_op_r  <= id_alu_operations_selector;
      ex_rd_r      <= id_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid_r <= 1'b0;
      mem_write_r <= 1'b0;
      mem_store_r <= 1'b0;
      mem_load_r  <= 1'b0;
      mem_rd_r    <= '0;
      wb_valid_r  <= 1'b0;
      wb_write_r  <= 1'b0;
      wb_load_r   <= 1'b0;
      wb_rd_r     <= '0;
    end else begin
      mem_valid_r <= ex_valid_r;
      mem_write_r <= ex_write_r;
      mem_store_r <= ex_store_r;
      mem_load_r  <= ex_load_r;
      mem_rd_r    <= ex_rd_r;
      wb_valid_r  <= mem_valid_r;
      wb_write_r  <= mem_write_r;
      wb_load_r   <= mem_load_r;
      wb_rd_r     <= mem_rd_r;
    end
  end

`ifdef CTRL_PIPE_COUNTERS_EN
  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (flush && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end
`endif

  assign ex_valid                   = ex_valid_r;
  assign ex_write                   = ex_write_r & ex_valid_r;
  assign ex_store                   = ex_store_r & ex_valid_r;
  assign ex_load                    = ex_load_r & ex_valid_r;
  assign ex_branch                  = ex_branch_r;
  assign ex_alu_operand_a_selector  = ex_a_sel_r;
  assign ex_alu_operand_b_selector  = ex_b_sel_r;
  assign ex_next_pc_selector        = ex_npc_sel_r;
  assign ex_alu_operations_selector = ex_alu_op_r;
  assign ex_rd                      = ex_rd_r;
  assign mem_valid                  = mem_valid_r;
  assign mem_write                  = mem_write_r & mem_valid_r;
  assign mem_store                  = mem_store_r & mem_valid_r;
  assign mem_load                   = mem_load_r & mem_valid_r;
  assign mem_rd                     = mem_rd_r;
  assign wb_valid                   = wb_valid_r;
  assign wb_write                   = wb_write_r & wb_valid_r;
  assign wb_load                    = wb_load_r & wb_valid_r;
  assign wb_rd                      = wb_rd_r;

endmodule
